bcd_counter_n: RTL and testbench

Parametrised N-digit packed-BCD up/down counter, the successor to the fixed 4-digit up-only BCD counter.
- Adds count enable, direction control, parallel load with digit validation, per-digit advance strobes and a terminal-count carry/borrow.
- Sits in the timer/display datapath: feeds 7-segment drivers and cascades into further counter stages through carry_out.

---
 rtl/bcd_counter_pkg.sv | 13 +
 rtl/bcd_digit_cell.sv | 39 +++
 rtl/bcd_counter_n.sv | 78 +++++++
 tb/tb_bcd_counter_n.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the N-digit packed-BCD counter.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: load with validation, step up/down with 9<->0 wrap.
module bcd_digit_cell
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up_dn,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       at_limit,
  output logic       bad_load
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // An out-of-range digit is replaced by zero so q never holds a non-BCD value.
      digit_d = bcd_valid(load_digit) ? load_digit : BCD_MIN;
    end else if (step) begin
      if (up_dn) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else       digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_q <= BCD_MIN;
    else       digit_q <= digit_d;
  end

  assign digit    = digit_q;
  assign at_limit = up_dn ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
  assign bad_load = load & ~bcd_valid(load_digit);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit packed-BCD up/down counter with load validation and carry/borrow.
// Define BCD_COUNTER_SAT_EN to saturate at 9..9 / 0..0 instead of wrapping.
module bcd_counter_n
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] q,
  output logic [NUM_DIGITS-1:0]   ena,
  output logic                    carry_out,
  output logic                    load_err
);

  logic                  count;
  logic                  all_limit;
  logic [NUM_DIGITS-1:0] chain;
  logic [NUM_DIGITS-1:0] step;
  logic [NUM_DIGITS-1:0] at_limit;
  logic [NUM_DIGITS-1:0] bad_load;
  logic                  load_err_q;
  logic                  load_err_d;
  logic                  run;

  // Gating with reset keeps the combinational strobes quiet while reset is held.
  assign count = en & ~load & ~reset;

  always_comb begin
    run   = count;
    chain = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      chain[i] = run;
      run      = run & at_limit[i];
    end
    all_limit = run;
`ifdef BCD_COUNTER_SAT_EN
    step = all_limit ? '0 : chain;
`else
    step = chain;
`endif
  end

  assign ena       = step;
  assign carry_out = all_limit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_t digit;

    bcd_digit_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .step       (step[g]),
      .up_dn      (up_dn),
      .load       (load),
      .load_digit (load_val[4*g +: 4]),
      .digit      (digit),
      .at_limit   (at_limit[g]),
      .bad_load   (bad_load[g])
    );

    assign q[4*g +: 4] = digit;
  end

  assign load_err_d = |bad_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) load_err_q <= 1'b0;
    else       load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed-vector bench for bcd_counter_n (4-digit and 2-digit instances).
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] q;
  logic [3:0]  ena;
  logic        carry_out;
  logic        load_err;
  logic [7:0]  q2;
  logic [1:0]  ena2;
  logic        carry2;
  logic        load_err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.NUM_DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q), .ena(ena), .carry_out(carry_out), .load_err(load_err)
  );

  bcd_counter_n #(.NUM_DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[7:0]), .q(q2), .ena(ena2), .carry_out(carry2), .load_err(load_err2)
  );

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic        en;
    logic        up;
    logic [3:0]  ena;
    logic        co;
    logic [15:0] q;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    int m4, m2, co4, co2, exp_co4, exp_co2;

    //            ld    load_val   en    up    ena      co    q_next     err
    vecs[0]  = '{1'b1, 16'h0099, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0099, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'b0111, 1'b0, 16'h0100, 1'b0};
    vecs[2]  = '{1'b1, 16'h9999, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h9999, 1'b0};
`ifdef BCD_COUNTER_SAT_EN
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 1'b1, 16'h9999, 1'b0};
`else
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'b1111, 1'b1, 16'h0000, 1'b0};
`endif
    vecs[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0};
`ifdef BCD_COUNTER_SAT_EN
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 16'h0000, 1'b0};
`else
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'b1111, 1'b1, 16'h9999, 1'b0};
`endif
    vecs[6]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h1000, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'b1111, 1'b0, 16'h0999, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'b0001, 1'b0, 16'h0998, 1'b0};
    vecs[9]  = '{1'b1, 16'h12A4, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h1204, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h1204, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'b0001, 1'b0, 16'h1205, 1'b0};
    vecs[12] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b1};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 16'h0009, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h0009, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'b0011, 1'b0, 16'h0010, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'b0011, 1'b0, 16'h0009, 1'b0};

    // Power-on reset
    #12;
    check("reset_q", 32'(q), 32'h0);
    check("reset_load_err", 32'(load_err), 32'h0);
    check("reset_ena", 32'(ena), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].en; up_dn = vecs[i].up;
      #1;
      check($sformatf("row%0d_ena", i), 32'(ena), 32'(vecs[i].ena));
      check($sformatf("row%0d_carry", i), 32'(carry_out), 32'(vecs[i].co));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_q", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("row%0d_load_err", i), 32'(load_err), 32'(vecs[i].err));
    end

    // Asynchronous reset in the middle of counting
    @(negedge clk);
    load = 1'b1; load_val = 16'h1234; en = 1'b0; up_dn = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_q", 32'(q), 32'h1234);
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_step", 32'(q), 32'h1235);
    #2 reset = 1'b1;
    #1;
    check("async_reset_q", 32'(q), 32'h0);
    check("async_reset_q2", 32'(q2), 32'h0);
    check("async_reset_ena", 32'(ena), 32'h0);
    check("async_reset_carry", 32'(carry_out), 32'h0);
    check("async_reset_load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_step%0d", k), 32'(q), 32'(to_bcd(k)));
    end

    // Long up-count against an integer model on both widths
    @(negedge clk);
    load = 1'b1; load_val = 16'h0000; en = 1'b1; up_dn = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    m4 = 0; m2 = 0; co4 = 0; co2 = 0; exp_co4 = 0; exp_co2 = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk); #1;
      if (m4 == 9999) exp_co4++;
      if (m2 == 99) exp_co2++;
      if (carry_out) co4++;
      if (carry2) co2++;
      check("run_carry4", 32'(carry_out), 32'(m4 == 9999));
      check("run_carry2", 32'(carry2), 32'(m2 == 99));
      @(posedge clk); #1;
`ifdef BCD_COUNTER_SAT_EN
      if (m4 < 9999) m4++;
      if (m2 < 99) m2++;
`else
      m4 = (m4 + 1) % 10000;
      m2 = (m2 + 1) % 100;
`endif
      check("run_q4", 32'(q), 32'(to_bcd(m4)));
      check("run_q2", 32'(q2), 32'(to_bcd(m2)));
      check("run_digits_le9", 32'(digits_ok(q)), 32'h1);
      if (n_fail > 20) break;
    end
    check("carry_count4", 32'(co4), 32'd1);
`ifdef BCD_COUNTER_SAT_EN
    check("carry_count2", 32'(co2), 32'd9901);
`else
    check("carry_count2", 32'(co2), 32'd100);
`endif
    check("carry_count2_model", 32'(co2), 32'(exp_co2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
